// File: rtl/rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// rx_frame_pkg
// Shared definitions for the UART frame sequencer:
//   - state_e      : FSM state encoding (HUNT=0, PAYLOAD=1, CSUM=2, RESYNC=3)
//   - CSUM_W       : width of the additive payload checksum
//   - ERR_W        : width of the saturating error counter
//   - TIMER_W      : width of the inter-byte / resync down-counter
//   - sat_inc_err  : saturating increment used for the error counter
// ---------------------------------------------------------------------------
package rx_frame_pkg;

    localparam int CSUM_W  = 8;
    localparam int ERR_W   = 8;
    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CSUM    = 2'd2,
        ST_RESYNC  = 2'd3
    } state_e;

    // Error count sticks at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end
        return v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/rx_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// rx_frame_sequencer_if
// Bundles the receiver-side byte handshake and the frame-buffer side outputs
// of the frame sequencer.
//   iValid     : byte-valid level from the UART receiver
//   iData      : received byte, stable while iValid is high
//   oRxAbort   : to receiver rstTx, aborts a stuck reception
//   oWrEn      : one-cycle payload write strobe
//   oWrAddr    : payload index
//   oWrData    : payload byte
//   oFrameDone : one-cycle pulse, frame complete with good checksum
//   oFrameErr  : one-cycle pulse, checksum mismatch or inter-byte timeout
//   oErrCnt    : saturating error count
// Modports:
//   master : the receiver / stimulus side (drives iValid, iData)
//   slave  : the sequencer (consumes bytes, drives everything else)
// ---------------------------------------------------------------------------
interface rx_frame_sequencer_if;

    logic       iValid;
    logic [7:0] iData;
    logic       oRxAbort;
    logic       oWrEn;
    logic [3:0] oWrAddr;
    logic [7:0] oWrData;
    logic       oFrameDone;
    logic       oFrameErr;
    logic [7:0] oErrCnt;

    modport master (
        output iValid,
        output iData,
        input  oRxAbort,
        input  oWrEn,
        input  oWrAddr,
        input  oWrData,
        input  oFrameDone,
        input  oFrameErr,
        input  oErrCnt
    );

    modport slave (
        input  iValid,
        input  iData,
        output oRxAbort,
        output oWrEn,
        output oWrAddr,
        output oWrData,
        output oFrameDone,
        output oFrameErr,
        output oErrCnt
    );

endinterface

// File: rtl/rx_byte_timer.sv
// ---------------------------------------------------------------------------
// rx_byte_timer
// Loadable down-counter shared by the inter-byte timeout and the RESYNC
// hold period.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   load_i     : load load_val_i into the counter (has priority over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one this cycle (stops at zero)
//   expired_o  : the counter holds 1, i.e. the decrement happening in this
//                cycle is the one that reaches zero. The owner qualifies it
//                with its own state so a stale value is never acted on.
// ---------------------------------------------------------------------------
module rx_byte_timer
    import rx_frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               expired_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flagging on 1 rather than 0 lets the FSM act on the same edge the
    // count runs out, so a load of L yields expiry L cycles after the load.
    assign expired_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/rx_frame_sequencer.sv
// ---------------------------------------------------------------------------
// rx_frame_sequencer
// Turns the UART receiver byte stream into fixed-length frames:
//   SYNC_BYTE, FRAME_LEN payload bytes, one 8-bit additive checksum.
// Payload bytes are written out to the frame buffer as they arrive; the
// checksum byte produces either a done or an error pulse. A stall between
// bytes inside a frame raises an error and pulses oRxAbort for RESYNC_LEN
// cycles to kick the receiver back to idle.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : rx_frame_sequencer_if.slave (byte input, write/status outputs)
// Parameters:
//   SYNC_BYTE  : frame header byte
//   FRAME_LEN  : payload bytes per frame (1..16)
//   TIMEOUT    : max cycles between byte strobes inside a frame (2..65535)
//   RESYNC_LEN : cycles oRxAbort is held high (>= 3)
// ---------------------------------------------------------------------------
module rx_frame_sequencer
    import rx_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         FRAME_LEN  = 4,
    parameter int         TIMEOUT    = 5000,
    parameter int         RESYNC_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_frame_sequencer_if.slave  bus
);

    // The timer reaches expiry exactly `load` cycles after being loaded, and
    // the output register adds one more cycle; loading TIMEOUT-1 therefore
    // puts oFrameErr exactly TIMEOUT cycles after the strobe cycle.
    localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT - 1);
    // In RESYNC the abort output is already high in the cycle after the
    // load, so a full RESYNC_LEN load gives RESYNC_LEN high cycles.
    localparam logic [TIMER_W-1:0] RS_LOAD  = TIMER_W'(RESYNC_LEN);
    localparam logic [3:0]         LAST_IDX = 4'(FRAME_LEN - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e              state_q;
    logic                valid_d_q;
    logic [3:0]          idx_q;
    logic [CSUM_W-1:0]   sum_q;
    logic                rx_abort_q;
    logic                wr_en_q;
    logic [3:0]          wr_addr_q;
    logic [7:0]          wr_data_q;
    logic                frame_done_q;
    logic                frame_err_q;
    logic [ERR_W-1:0]    err_cnt_q;

    // ------------------------------------------------------------------
    // Byte strobe: one pulse on the rising edge of the receiver's valid
    // level, however many cycles the level is held.
    // ------------------------------------------------------------------
    logic strb;
    assign strb = bus.iValid & ~valid_d_q;

    // ------------------------------------------------------------------
    // Timer control
    // ------------------------------------------------------------------
    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_load_val;
    logic               tmr_en;
    logic               tmr_expired;
    logic               timeout_hit;

    // Expiry only counts where the timer is running for this state, and a
    // strobe in the same cycle always takes priority.
    assign timeout_hit = tmr_expired && !strb &&
                         ((state_q == ST_PAYLOAD) || (state_q == ST_CSUM));

    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = TO_LOAD;
        tmr_en       = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (strb && (bus.iData == SYNC_BYTE)) begin
                    tmr_load = 1'b1;
                end
            end
            ST_PAYLOAD, ST_CSUM: begin
                if (strb) begin
                    // Reload on every accepted byte; in CSUM the frame ends
                    // here so the reload is harmless.
                    tmr_load = 1'b1;
                end else if (timeout_hit) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = RS_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESYNC: begin
                tmr_en = 1'b1;
            end
            default: begin
                tmr_en = 1'b0;
            end
        endcase
    end

    rx_byte_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .expired_o  (tmr_expired)
    );

    // ------------------------------------------------------------------
    // Frame FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_HUNT;
            valid_d_q    <= 1'b0;
            idx_q        <= '0;
            sum_q        <= '0;
            rx_abort_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            valid_d_q    <= bus.iValid;
            // Pulses default low; address/data hold their last value.
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;

            unique case (state_q)
                ST_HUNT: begin
                    if (strb && (bus.iData == SYNC_BYTE)) begin
                        state_q <= ST_PAYLOAD;
                        idx_q   <= '0;
                        sum_q   <= '0;
                    end
                end

                ST_PAYLOAD: begin
                    if (strb) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q;
                        wr_data_q <= bus.iData;
                        sum_q     <= sum_q + bus.iData;
                        idx_q     <= idx_q + 4'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_CSUM;
                        end
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc_err(err_cnt_q);
                        rx_abort_q  <= 1'b1;
                        state_q     <= ST_RESYNC;
                    end
                end

                ST_CSUM: begin
                    if (strb) begin
                        if (bus.iData == sum_q) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_cnt_q   <= sat_inc_err(err_cnt_q);
                        end
                        state_q <= ST_HUNT;
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc_err(err_cnt_q);
                        rx_abort_q  <= 1'b1;
                        state_q     <= ST_RESYNC;
                    end
                end

                ST_RESYNC: begin
                    // Strobes are ignored while the receiver is held off.
                    if (tmr_expired) begin
                        rx_abort_q <= 1'b0;
                        state_q    <= ST_HUNT;
                    end
                end

                default: begin
                    state_q <= ST_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign bus.oRxAbort   = rx_abort_q;
    assign bus.oWrEn      = wr_en_q;
    assign bus.oWrAddr    = wr_addr_q;
    assign bus.oWrData    = wr_data_q;
    assign bus.oFrameDone = frame_done_q;
    assign bus.oFrameErr  = frame_err_q;
    assign bus.oErrCnt    = err_cnt_q;

endmodule

// File: tb/tb_rx_frame_sequencer.sv
module tb_rx_frame_sequencer;

    localparam int         TIMEOUT    = 64;
    localparam int         RESYNC_LEN = 4;
    localparam logic [7:0] SYNC       = 8'hA5;

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_CERR = 2;
    localparam int K_TERR = 3;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;

    rx_frame_sequencer_if bus ();

    rx_frame_sequencer #(
        .SYNC_BYTE  (SYNC),
        .FRAME_LEN  (4),
        .TIMEOUT    (TIMEOUT),
        .RESYNC_LEN (RESYNC_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    int unsigned strobe_cyc = 0;
    int   model_err = 0;
    int   abort_len = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        if (kind == K_CERR || kind == K_TERR) begin
            if (model_err < 255) model_err++;
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic send_byte(input logic [7:0] d, input int w);
        bus.iValid = 1'b1;
        bus.iData  = d;
        strobe_cyc = cyc;
        repeat (w) @(negedge clk);
        bus.iValid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] pl, input logic [7:0] csum_xor, input int w);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b = pl[8*i +: 8];
            s = s + b;
            push_exp(K_WR, 4'(i), b);
        end
        push_exp((csum_xor == 8'h00) ? K_DONE : K_CERR, 4'd0, 8'h00);
        send_byte(SYNC, w);
        for (int i = 0; i < 4; i++) begin
            b = pl[8*i +: 8];
            send_byte(b, w);
        end
        send_byte(s ^ csum_xor, w);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_val(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor and abort-width tracker.
    exp_t e_mon;
    always @(negedge clk) begin
        if (bus.oWrEn || bus.oFrameDone || bus.oFrameErr) begin
            if (sb.size() == 0) begin
                check_val("unexpected_evt", 32'({bus.oWrEn, bus.oFrameDone, bus.oFrameErr}), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                if (e_mon.kind == K_WR) begin
                    check_val("wr_kind", 32'({bus.oWrEn, bus.oFrameDone, bus.oFrameErr}), 32'b100);
                    check_val("wr_addr", 32'(bus.oWrAddr), 32'(e_mon.addr));
                    check_val("wr_data", 32'(bus.oWrData), 32'(e_mon.data));
                end else if (e_mon.kind == K_DONE) begin
                    check_val("done_kind", 32'({bus.oWrEn, bus.oFrameDone, bus.oFrameErr}), 32'b010);
                end else begin
                    check_val("err_kind", 32'({bus.oWrEn, bus.oFrameDone, bus.oFrameErr}), 32'b001);
                    if (e_mon.kind == K_TERR) begin
                        check_val("to_cycles", cyc - strobe_cyc, 32'(TIMEOUT));
                        check_val("abort_rise", 32'(bus.oRxAbort), 32'd1);
                        check_val("abort_prev", 32'(abort_len), 32'd0);
                    end else begin
                        check_val("csum_no_abort", 32'(bus.oRxAbort), 32'd0);
                    end
                end
            end
        end
        if (bus.oRxAbort) begin
            abort_len = abort_len + 1;
        end else if (abort_len != 0) begin
            check_val("abort_len", 32'(abort_len), 32'(RESYNC_LEN));
            abort_len = 0;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_outs"}, 32'({bus.oRxAbort, bus.oWrEn, bus.oWrAddr, bus.oWrData,
                                       bus.oFrameDone, bus.oFrameErr, bus.oErrCnt}), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        bus.iValid = 1'b0;
        bus.iData  = 8'h00;
        #1;
        check_idle_outputs("reset_async");
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Good frame.
        send_frame(32'h04030201, 8'h00, 3);
        drain("good_drain", 20);
        check_val("good_errcnt", 32'(bus.oErrCnt), 32'(model_err));

        // Bad checksum followed by a good frame.
        send_frame(32'h04030201, 8'h01, 3);
        drain("badcs_drain", 20);
        check_val("badcs_errcnt", 32'(bus.oErrCnt), 32'(model_err));
        send_frame(32'h5A6B7C8D, 8'h00, 2);
        drain("after_bad_drain", 20);

        // Stall mid-payload -> timeout, abort, then back in HUNT.
        push_exp(K_WR, 4'd0, 8'h01);
        push_exp(K_TERR, 4'd0, 8'h00);
        send_byte(SYNC, 3);
        send_byte(8'h01, 3);
        drain("timeout_drain", TIMEOUT + 20);
        repeat (RESYNC_LEN + 3) @(negedge clk);
        check_val("timeout_abort_low", 32'(bus.oRxAbort), 32'd0);
        check_val("timeout_errcnt", 32'(bus.oErrCnt), 32'(model_err));
        send_frame(32'h000000A5, 8'h00, 3);
        drain("post_timeout_drain", 20);

        // Noise before sync, then widths 1 and 5.
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h5A, 3);
        check_val("noise_errcnt", 32'(bus.oErrCnt), 32'(model_err));
        send_frame(32'h11223344, 8'h00, 1);
        drain("w1_drain", 20);
        send_frame(32'hA5A5A5A5, 8'h00, 5);
        drain("w5_drain", 20);

        // Reset mid-payload.
        push_exp(K_WR, 4'd0, 8'h11);
        send_byte(SYNC, 2);
        bus.iValid = 1'b1;
        bus.iData  = 8'h11;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        model_err = 0;
        @(negedge clk);
        bus.iValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_byte(8'h22, 2);
        send_byte(8'h33, 2);
        send_byte(8'h44, 2);
        send_byte(8'h0A, 2);
        drain("midreset_drain", 10);
        check_val("midreset_errcnt", 32'(bus.oErrCnt), 32'd0);

        // Saturation of the error counter.
        for (int f = 0; f < 300; f++) begin
            send_frame(32'($urandom), 8'(1 + (f % 255)), 1);
        end
        drain("sat_drain", 20);
        check_val("sat_errcnt", 32'(bus.oErrCnt), 32'(model_err));
        check_val("sat_ff", 32'(bus.oErrCnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
